// File: rtl/big_fb_scheduler_pkg.sv
// Shared definitions for the BIG framebuffer access scheduler.
package big_fb_scheduler_pkg;

  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned DATA_W_DEF = 6;

  // Read window: DISPLAY while the VGA driver owns the read port, BLANK otherwise.
  typedef enum logic {
    WIN_DISPLAY = 1'b0,
    WIN_BLANK   = 1'b1
  } win_state_e;

endpackage

// File: rtl/big_fb_scheduler_if.sv
// Bundle of VGA, client and framebuffer signals seen by the scheduler.
interface big_fb_scheduler_if #(
  parameter int unsigned ADDR_W = big_fb_scheduler_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = big_fb_scheduler_pkg::DATA_W_DEF
);

  logic              vga_active;
  logic [ADDR_W-1:0] vga_rd_addr;

  logic              c0_req;
  logic              c0_we;
  logic [ADDR_W-1:0] c0_addr;
  logic [DATA_W-1:0] c0_wdata;
  logic              c0_gnt;
  logic              c0_rvalid;
  logic [DATA_W-1:0] c0_rdata;

  logic              c1_req;
  logic              c1_we;
  logic [ADDR_W-1:0] c1_addr;
  logic [DATA_W-1:0] c1_wdata;
  logic              c1_gnt;
  logic              c1_rvalid;
  logic [DATA_W-1:0] c1_rdata;

  logic [ADDR_W-1:0] fb_rd_addr;
  logic [DATA_W-1:0] fb_rd_data;
  logic              fb_wr_en;
  logic [ADDR_W-1:0] fb_wr_addr;
  logic [DATA_W-1:0] fb_wr_data;

  // Scheduler side.
  modport slave (
    input  vga_active, vga_rd_addr,
    input  c0_req, c0_we, c0_addr, c0_wdata,
    output c0_gnt, c0_rvalid, c0_rdata,
    input  c1_req, c1_we, c1_addr, c1_wdata,
    output c1_gnt, c1_rvalid, c1_rdata,
    output fb_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data,
    input  fb_rd_data
  );

  // Environment side: clients, VGA driver and framebuffer.
  modport master (
    output vga_active, vga_rd_addr,
    output c0_req, c0_we, c0_addr, c0_wdata,
    input  c0_gnt, c0_rvalid, c0_rdata,
    output c1_req, c1_we, c1_addr, c1_wdata,
    input  c1_gnt, c1_rvalid, c1_rdata,
    input  fb_rd_addr, fb_wr_en, fb_wr_addr, fb_wr_data,
    output fb_rd_data
  );

endinterface

// File: rtl/big_fb_scheduler_rr_arb2.sv
// Two-way round-robin arbiter with a combinational grant and a last-grant pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // last_q = index of the client granted most recently; reset value 1 favours client 0.
  logic last_q;
  logic last_d;

  // Grant selection and pointer next state.
  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    if (gnt_o[1]) begin
      last_d = 1'b1;
    end else if (gnt_o[0]) begin
      last_d = 1'b0;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/big_fb_scheduler.sv
// Schedules two clients onto the BIG framebuffer write and read ports,
// keeping reads out of the VGA display window.
module big_fb_scheduler #(
  parameter int unsigned ADDR_W = big_fb_scheduler_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = big_fb_scheduler_pkg::DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  big_fb_scheduler_if.slave bus
);

  import big_fb_scheduler_pkg::*;

  win_state_e        win_q;
  win_state_e        win_d;
  logic              rd_open_c;

  logic [1:0]        wr_req_c;
  logic [1:0]        wr_gnt_c;
  logic [1:0]        rd_raw_c;
  logic [1:0]        rd_req_c;
  logic [1:0]        rd_gnt_c;
  logic              wr_any_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [DATA_W-1:0] wr_data_c;

  logic [1:0]        rvalid_q;
  logic [1:0]        rvalid_d;
  logic [DATA_W-1:0] rhold0_q;
  logic [DATA_W-1:0] rhold0_d;
  logic [DATA_W-1:0] rhold1_q;
  logic [DATA_W-1:0] rhold1_d;

  // Window FSM next state; the read window follows the current vga_active level.
  always_comb begin
    win_d = win_q;
    case (win_q)
      WIN_DISPLAY: if (!bus.vga_active) win_d = WIN_BLANK;
      WIN_BLANK:   if (bus.vga_active)  win_d = WIN_DISPLAY;
      default:     win_d = WIN_DISPLAY;
    endcase
    rd_open_c = (win_d == WIN_BLANK);
  end

  // Window FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= WIN_DISPLAY;
    end else begin
      win_q <= win_d;
    end
  end

  // Write requests; no grants while reset is held.
  always_comb begin
    wr_req_c = 2'b00;
    if (!rst) begin
      wr_req_c = {bus.c1_req & bus.c1_we, bus.c0_req & bus.c0_we};
    end
  end

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (wr_req_c),
    .gnt_o (wr_gnt_c)
  );

  // Write port mux, driven straight from the granted client's inputs.
  always_comb begin
    wr_any_c  = |wr_gnt_c;
    wr_addr_c = wr_gnt_c[1] ? bus.c1_addr  : bus.c0_addr;
    wr_data_c = wr_gnt_c[1] ? bus.c1_wdata : bus.c0_wdata;
    bus.fb_wr_en   = wr_any_c;
    bus.fb_wr_addr = wr_addr_c;
    bus.fb_wr_data = wr_data_c;
  end

  // Read requests: blank window only, deferred when colliding with this cycle's write.
  always_comb begin
    rd_raw_c = 2'b00;
    if (!rst && rd_open_c) begin
      rd_raw_c = {bus.c1_req & ~bus.c1_we, bus.c0_req & ~bus.c0_we};
    end
    rd_req_c    = rd_raw_c;
    rd_req_c[0] = rd_raw_c[0] & ~(wr_any_c && (bus.c0_addr == wr_addr_c));
    rd_req_c[1] = rd_raw_c[1] & ~(wr_any_c && (bus.c1_addr == wr_addr_c));
  end

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (rd_req_c),
    .gnt_o (rd_gnt_c)
  );

  // Read address mux and client grant pulses.
  always_comb begin
    bus.fb_rd_addr = bus.vga_rd_addr;
    if (rd_gnt_c[1]) begin
      bus.fb_rd_addr = bus.c1_addr;
    end else if (rd_gnt_c[0]) begin
      bus.fb_rd_addr = bus.c0_addr;
    end
    bus.c0_gnt = wr_gnt_c[0] | rd_gnt_c[0];
    bus.c1_gnt = wr_gnt_c[1] | rd_gnt_c[1];
  end

  // Return path: data valid one cycle after the grant, last value held otherwise.
  always_comb begin
    rvalid_d = rd_gnt_c;
    rhold0_d = rvalid_q[0] ? bus.fb_rd_data : rhold0_q;
    rhold1_d = rvalid_q[1] ? bus.fb_rd_data : rhold1_q;
    bus.c0_rvalid = rvalid_q[0];
    bus.c1_rvalid = rvalid_q[1];
    bus.c0_rdata  = rhold0_d;
    bus.c1_rdata  = rhold1_d;
  end

  // Return-path registers; reset drops any read still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 2'b00;
      rhold0_q <= '0;
      rhold1_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rhold0_q <= rhold0_d;
      rhold1_q <= rhold1_d;
    end
  end

endmodule

// File: doc/big_fb_scheduler.md
BIG_FB_SCHEDULER -- requirements
Module: big_fb_scheduler

Interface
REQ-001 Parameter ADDR_W, default 11, BIG framebuffer address width.
REQ-002 Parameter DATA_W, default 6, pixel width.
REQ-003 clk  in  1  single system clock, all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 vga_active  in  1  high while the VGA driver owns the framebuffer read port.
REQ-006 vga_rd_addr  in  ADDR_W  VGA driver read address.
REQ-007 cN_req, cN_we  in  1 each  client N (N=0,1) request and write/not-read qualifier.
REQ-008 cN_addr, cN_wdata  in  ADDR_W, DATA_W  client N address and write data.
REQ-009 cN_gnt  out  1  one-cycle grant pulse to client N.
REQ-010 cN_rvalid  out  1  read data valid for client N.
REQ-011 cN_rdata  out  DATA_W  read data for client N.
REQ-012 fb_rd_addr  out  ADDR_W  framebuffer read address.
REQ-013 fb_rd_data  in  DATA_W  framebuffer read data, 1-cycle synchronous latency.
REQ-014 fb_wr_en, fb_wr_addr, fb_wr_data  out  1, ADDR_W, DATA_W  framebuffer write port.

Function
REQ-015 Client holds req/we/addr/wdata stable from req assertion through the cycle its gnt is high; deasserts or presents a new request the following cycle.
REQ-016 Write port and read port arbitrated independently, each round-robin between client 0 and 1, one grant per port per cycle.
REQ-017 Round-robin: on contention grant the client not granted last on that port; pointer updates only on a grant; reset pointer favours client 0.
REQ-018 Write grant allowed in any cycle regardless of vga_active; in grant cycle fb_wr_en=1, fb_wr_addr/fb_wr_data = granted client's addr/wdata (combinational from inputs).
REQ-019 Window FSM states DISPLAY and BLANK: DISPLAY->BLANK when vga_active=0, BLANK->DISPLAY when vga_active=1; registered state, combinational read-grant qualification uses current vga_active.
REQ-020 Read grant only when vga_active=0; fb_rd_addr = granted client's addr in grant cycle, otherwise vga_rd_addr.
REQ-021 Read issued in cycle N: cN_rvalid=1 and cN_rdata=fb_rd_data in cycle N+1 exactly, even if vga_active rises in N+1.
REQ-022 cN_rdata holds last returned value when rvalid=0.
REQ-023 Both clients may be granted in the same cycle, one on each port.
REQ-024 Same-address hazard: if the read candidate address equals the write being granted that cycle, read grant deferred one cycle; write proceeds.
REQ-025 A client never receives two grants in one cycle.
REQ-026 Read requests during DISPLAY wait without limit; no grant, no error.

Reset
REQ-027 On rst: all gnt, rvalid, fb_wr_en = 0; rdata = 0; FSM = DISPLAY; both RR pointers favour client 0; fb_rd_addr follows vga_rd_addr.
REQ-028 rst mid-operation discards any in-flight read; no rvalid after reset release for a pre-reset grant.
REQ-029 Outputs valid from first clock edge after rst deasserts.

Structure
REQ-030 Shared package holds ADDR_W/DATA_W defaults and the window-state enumeration.
REQ-031 One sub-module rr_arb2 (2-way round-robin, req in, gnt out, pointer state), instantiated once per port.

Verification
REQ-032 vga_active=1, c0 write addr 0x123 data 0x2A -> c0_gnt same cycle, fb_wr_en=1, fb_wr_addr=0x123, fb_wr_data=0x2A.
REQ-033 vga_active=1, c1 read addr 0x010 held 5 cycles, then vga_active=0 -> c1_gnt first blank cycle, fb_rd_addr=0x010, c1_rvalid next cycle with stored value.
REQ-034 vga_active=0, both clients read continuously -> grants alternate c0,c1,c0,c1; rvalid matches each one cycle later.
REQ-035 vga_active=0, c0 write 0x055 and c1 read 0x055 same cycle -> write granted, read granted next cycle, c1_rdata = new value.
REQ-036 Read granted, vga_active rises next cycle -> rvalid still asserted, correct data; fb_rd_addr returns to vga_rd_addr.
REQ-037 rst asserted one cycle after read grant -> no rvalid, all outputs at reset values, c0 favoured first after release.
